// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  // State names the owner of the most recently granted cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Tag carried alongside an outstanding read so the data finds its way home.
  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Delay line that tracks outstanding reads for RD_LAT cycles, matching RAM latency.
module sram_rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LAT];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters,
// with bounded bursts and tagged read-data return.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;

  logic    w_gnt0, w_gnt1, w_under;
  rd_tag_t w_tag_in, w_tag_out;

  // Grant decision: owner keeps the port until its burst budget runs out
  // while the other side waits; from idle, contention goes to !last.
  always_comb begin
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_under = (r_cnt < CNT_W'(MAX_BURST));
    if (!rst) begin
      case (r_state)
        ST_OWN0: begin
          if (req0 && (!req1 || w_under)) w_gnt0 = 1'b1;
          else if (req1)                  w_gnt1 = 1'b1;
        end
        ST_OWN1: begin
          if (req1 && (!req0 || w_under)) w_gnt1 = 1'b1;
          else if (req0)                  w_gnt0 = 1'b1;
        end
        default: begin
          if (req0 && req1) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
        end
      endcase
    end
  end

  // Ownership FSM with saturating burst counter and last-winner memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else if (w_gnt0) begin
      if (r_state == ST_OWN0) r_cnt <= w_under ? r_cnt + CNT_W'(1) : r_cnt;
      else                    r_cnt <= CNT_W'(1);
      r_state <= ST_OWN0;
      r_last  <= 1'b0;
    end else if (w_gnt1) begin
      if (r_state == ST_OWN1) r_cnt <= w_under ? r_cnt + CNT_W'(1) : r_cnt;
      else                    r_cnt <= CNT_W'(1);
      r_state <= ST_OWN1;
      r_last  <= 1'b1;
    end else begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end
  end

  // RAM port mux: winner's fields, zeros when nobody is granted.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (w_gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  assign w_tag_in.vld  = (w_gnt0 && !we0) || (w_gnt1 && !we1);
  assign w_tag_in.port = w_gnt1;

  sram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Return demux; rst masks a tag still sitting at the pipe output.
  always_comb begin
    rvalid0 = w_tag_out.vld && !w_tag_out.port && !rst;
    rvalid1 = w_tag_out.vld &&  w_tag_out.port && !rst;
    rdata0  = rvalid0 ? ram_dout : '0;
    rdata1  = rvalid1 ? ram_dout : '0;
  end

endmodule
